// File: rtl/mask_rnd_source.sv
// Fresh-randomness source for masked gadgets: seeded Fibonacci LFSR unrolled N_RND steps
// per clock, delivered through a registered valid/ready output.
module mask_rnd_source #(
  parameter int unsigned      N_RND  = 4,
  parameter int unsigned      LFSR_W = 64,
  parameter logic [LFSR_W-1:0] TAPS  = 64'hD800_0000_0000_0000,
  parameter int unsigned      SEED_W = 16,
  parameter int unsigned      WARM   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SEED_W-1:0] seed_data_i,
  input  logic              seed_valid_i,
  output logic              seed_ready_o,
  input  logic              reseed_i,
  output logic [N_RND-1:0]  rnd_o,
  output logic              rnd_valid_o,
  input  logic              rnd_ready_i,
  output logic              busy_o,
  output logic [15:0]       word_cnt_o
);

  localparam int unsigned Beats = LFSR_W / SEED_W;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned WarmW = (WARM > 1) ? $clog2(WARM) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(Beats - 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARM - 1);

  typedef enum logic [1:0] {StLoad, StWarmup, StRun} state_e;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [WarmW-1:0]   warm_q, warm_d;
  logic [N_RND-1:0]   rnd_q, rnd_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic [15:0]        word_cnt_q, word_cnt_d;

  logic [LFSR_W-1:0]  lfsr_step;
  logic [N_RND-1:0]   word_step;
  logic [LFSR_W-1:0]  seed_shift;

  // N_RND chained LFSR steps; the feedback bit of step i becomes word bit i.
  always_comb begin
    lfsr_step = lfsr_q;
    word_step = '0;
    for (int i = 0; i < N_RND; i++) begin
      word_step[i] = ^(lfsr_step & TAPS);
      lfsr_step    = {lfsr_step[LFSR_W-2:0], word_step[i]};
    end
  end

  assign seed_shift = {lfsr_q[LFSR_W-SEED_W-1:0], seed_data_i};

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    beat_d      = beat_q;
    warm_d      = warm_q;
    rnd_d       = rnd_q;
    rnd_valid_d = rnd_valid_q;
    word_cnt_d  = word_cnt_q;

    if (rnd_valid_q && rnd_ready_i && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end

    if (reseed_i) begin
      // LFSR state is left alone; the next full seed overwrites it completely.
      state_d     = StLoad;
      beat_d      = '0;
      warm_d      = '0;
      rnd_d       = '0;
      rnd_valid_d = 1'b0;
      word_cnt_d  = '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (seed_valid_i) begin
            lfsr_d = seed_shift;
            beat_d = beat_q + BeatW'(1);
            if (beat_q == BeatLast) begin
              beat_d = '0;
              warm_d = '0;
              // An all-zero state would lock the LFSR; kick it out of the zero orbit.
              if (seed_shift == '0) begin
                lfsr_d[0] = 1'b1;
              end
              state_d = (WARM == 0) ? StRun : StWarmup;
            end
          end
        end
        StWarmup: begin
          lfsr_d = lfsr_step;
          warm_d = warm_q + WarmW'(1);
          if (warm_q == WarmLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!rnd_valid_q || rnd_ready_i) begin
            rnd_d       = word_step;
            rnd_valid_d = 1'b1;
            lfsr_d      = lfsr_step;
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StLoad;
      lfsr_q      <= '0;
      beat_q      <= '0;
      warm_q      <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      beat_q      <= beat_d;
      warm_q      <= warm_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign seed_ready_o = (state_q == StLoad);
  assign busy_o       = (state_q != StRun);
  assign rnd_o        = rnd_q;
  assign rnd_valid_o  = rnd_valid_q;
  assign word_cnt_o   = word_cnt_q;

endmodule
